// File: rtl/store_port_sequencer_if.sv
// rtl/store_port_sequencer_if.sv - store-buffer, AMO and shared D$ port signals of the store port sequencer (drain_wdog_o only with STORE_PORT_SEQ_DRAIN_WDOG_EN)
interface store_port_sequencer_if #(
    parameter int unsigned PLEN = 56,
    parameter int unsigned XLEN = 64
);
    logic                flush_i;

    logic                sb_req_i;
    logic [PLEN-1:0]     sb_addr_i;
    logic [XLEN-1:0]     sb_wdata_i;
    logic [XLEN/8-1:0]   sb_be_i;
    logic [1:0]          sb_size_i;
    logic                sb_gnt_o;
    logic                sb_empty_i;
    logic                sb_stall_o;

    logic                amo_req_i;
    logic [PLEN-1:0]     amo_addr_i;
    logic [XLEN-1:0]     amo_wdata_i;
    logic [XLEN/8-1:0]   amo_be_i;
    logic [1:0]          amo_size_i;
    logic                amo_ack_o;
    logic [XLEN-1:0]     amo_rdata_o;

    logic                mem_req_o;
    logic                mem_we_o;
    logic [PLEN-1:0]     mem_addr_o;
    logic [XLEN-1:0]     mem_wdata_o;
    logic [XLEN/8-1:0]   mem_be_o;
    logic [1:0]          mem_size_o;
    logic                mem_gnt_i;
    logic                mem_rvalid_i;
    logic [XLEN-1:0]     mem_rdata_i;

    logic                busy_o;
`ifdef STORE_PORT_SEQ_DRAIN_WDOG_EN
    logic                drain_wdog_o;
`endif

    // Environment side: store buffer, AMO unit and D$ model
    modport master (
        output flush_i,
        output sb_req_i, sb_addr_i, sb_wdata_i, sb_be_i, sb_size_i, sb_empty_i,
        input  sb_gnt_o, sb_stall_o,
        output amo_req_i, amo_addr_i, amo_wdata_i, amo_be_i, amo_size_i,
        input  amo_ack_o, amo_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, mem_size_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  busy_o
`ifdef STORE_PORT_SEQ_DRAIN_WDOG_EN
        , input drain_wdog_o
`endif
    );

    // Sequencer side
    modport slave (
        input  flush_i,
        input  sb_req_i, sb_addr_i, sb_wdata_i, sb_be_i, sb_size_i, sb_empty_i,
        output sb_gnt_o, sb_stall_o,
        input  amo_req_i, amo_addr_i, amo_wdata_i, amo_be_i, amo_size_i,
        output amo_ack_o, amo_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, mem_size_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output busy_o
`ifdef STORE_PORT_SEQ_DRAIN_WDOG_EN
        , output drain_wdog_o
`endif
    );
endinterface

// File: rtl/store_port_sequencer.sv
// rtl/store_port_sequencer.sv - arbitrates the shared D$ port between store buffer and AMOs (optional drain watchdog: STORE_PORT_SEQ_DRAIN_WDOG_EN)
module store_port_sequencer #(
    parameter int unsigned PLEN        = 56,
    parameter int unsigned XLEN        = 64,
    parameter int unsigned DRAIN_LIMIT = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    store_port_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        ISSUE    = 2'd2,
        WAIT_RSP = 2'd3
    } state_e;

    // A watchdog shorter than two cycles cannot both count and then stall
    if (DRAIN_LIMIT < 2) begin : g_limit_check
        $error("DRAIN_LIMIT must be at least 2");
    end

    state_e              state_q;
    logic                busy_q;
    logic                stall_q;

    logic [PLEN-1:0]     amo_addr_q;
    logic [XLEN-1:0]     amo_wdata_q;
    logic [XLEN/8-1:0]   amo_be_q;
    logic [1:0]          amo_size_q;

    logic                sb_route;
    logic                sb_grant;
    logic                drain_done;
    logic                wdog_stall;
    logic                wdog_fire;

    logic                mem_req;
    logic                mem_we;
    logic [PLEN-1:0]     mem_addr;
    logic [XLEN-1:0]     mem_wdata;
    logic [XLEN/8-1:0]   mem_be;
    logic [1:0]          mem_size;

`ifdef STORE_PORT_SEQ_DRAIN_WDOG_EN
    localparam int unsigned    CNT_W   = $clog2(DRAIN_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DRAIN_LIMIT - 1);

    logic [CNT_W-1:0] wdog_cnt_q;

    // Once the counter saturates the store buffer is held off for the rest of DRAIN
    assign wdog_stall = (state_q == DRAIN) && (wdog_cnt_q == CNT_MAX);
    // Exit on timeout as soon as the store buffer has backed off; a flush takes priority
    assign wdog_fire  = wdog_stall && !bus.flush_i && (!bus.sb_req_i || bus.sb_empty_i);
    assign bus.drain_wdog_o = wdog_fire;

    // Count cycles spent in DRAIN, saturating at the limit; zero outside DRAIN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdog_cnt_q <= '0;
        end else if (state_q == DRAIN) begin
            if (!wdog_stall) begin
                wdog_cnt_q <= wdog_cnt_q + 1'b1;
            end
        end else begin
            wdog_cnt_q <= '0;
        end
    end
`else
    assign wdog_stall = 1'b0;
    assign wdog_fire  = 1'b0;
`endif

    // Store buffer owns the port in IDLE and DRAIN unless the watchdog has cut it off
    assign sb_route   = (state_q == IDLE) || ((state_q == DRAIN) && !wdog_stall);
    assign sb_grant   = sb_route && bus.mem_gnt_i;
    // A store granted this cycle means the buffer is not yet drained
    assign drain_done = bus.sb_empty_i && !sb_grant;

    // Port multiplexer: store-buffer writes or the captured AMO
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b1;
        mem_addr  = bus.sb_addr_i;
        mem_wdata = bus.sb_wdata_i;
        mem_be    = bus.sb_be_i;
        mem_size  = bus.sb_size_i;
        unique case (state_q)
            IDLE, DRAIN: begin
                mem_req = bus.sb_req_i && !wdog_stall;
            end
            ISSUE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b0;
                mem_addr  = amo_addr_q;
                mem_wdata = amo_wdata_q;
                mem_be    = amo_be_q;
                mem_size  = amo_size_q;
            end
            WAIT_RSP: begin
                mem_we    = 1'b0;
                mem_addr  = amo_addr_q;
                mem_wdata = amo_wdata_q;
                mem_be    = amo_be_q;
                mem_size  = amo_size_q;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

    // Handshakes are forced low while reset is held, since IDLE routing is combinational
    assign bus.mem_req_o   = rst_ni && mem_req;
    assign bus.mem_we_o    = mem_we;
    assign bus.mem_addr_o  = mem_addr;
    assign bus.mem_wdata_o = mem_wdata;
    assign bus.mem_be_o    = mem_be;
    assign bus.mem_size_o  = mem_size;
    assign bus.sb_gnt_o    = rst_ni && sb_grant;
    assign bus.sb_stall_o  = stall_q || wdog_stall;
    assign bus.amo_ack_o   = (state_q == WAIT_RSP) && bus.mem_rvalid_i;
    assign bus.amo_rdata_o = bus.mem_rdata_i;
    assign bus.busy_o      = busy_q;

    // Sequencer FSM with registered busy/stall flags and AMO capture
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            stall_q     <= 1'b0;
            amo_addr_q  <= '0;
            amo_wdata_q <= '0;
            amo_be_q    <= '0;
            amo_size_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.amo_req_i && !bus.flush_i) begin
                        state_q     <= DRAIN;
                        busy_q      <= 1'b1;
                        amo_addr_q  <= bus.amo_addr_i;
                        amo_wdata_q <= bus.amo_wdata_i;
                        amo_be_q    <= bus.amo_be_i;
                        amo_size_q  <= bus.amo_size_i;
                    end
                end
                DRAIN: begin
                    if (bus.flush_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (drain_done || wdog_fire) begin
                        state_q <= ISSUE;
                        stall_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    // Flush is not honoured here: the AMO is already committed
                    if (bus.mem_gnt_i) begin
                        state_q <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (bus.mem_rvalid_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        stall_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_port_sequencer.sv
// tb/tb_store_port_sequencer.sv - directed vector bench for store_port_sequencer
module tb_store_port_sequencer;
    localparam int unsigned PLEN = 56;
    localparam int unsigned XLEN = 64;
`ifdef STORE_PORT_SEQ_DRAIN_WDOG_EN
    localparam int unsigned DLIM = 8;
`else
    localparam int unsigned DLIM = 256;
`endif

    localparam logic [55:0] A_SB   = 56'h8000_0010;
    localparam logic [55:0] A1     = 56'h8000_0020;
    localparam logic [55:0] A2     = 56'h8000_0028;
    localparam logic [55:0] A3     = 56'h8000_0030;
    localparam logic [55:0] A4     = 56'h8000_0038;
    localparam logic [55:0] A_AMO  = 56'h8000_1000;
    localparam logic [55:0] A_AMO2 = 56'h8000_2000;
    localparam logic [55:0] A_BAD  = 56'h0000_0BAD;
    localparam logic [55:0] A5     = 56'h8000_3000;
    localparam logic [63:0] W5     = 64'hCAFE_F00D_1234_ABCD;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    store_port_sequencer_if #(.PLEN(PLEN), .XLEN(XLEN)) bus ();

    store_port_sequencer #(
        .PLEN        (PLEN),
        .XLEN        (XLEN),
        .DRAIN_LIMIT (DLIM)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus.slave)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        sbr;
        logic [55:0] sba;
        logic        emp;
        logic        amor;
        logic [55:0] amoa;
        logic        fl;
        logic        gnt;
        logic        rv;
        logic [63:0] rd;
        logic        e_req;
        logic        e_we;
        logic [55:0] e_addr;
        logic        e_sgnt;
        logic        e_stall;
        logic        e_ack;
        logic        e_busy;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic sbr, input logic [55:0] sba, input logic emp, input logic amor,
        input logic [55:0] amoa, input logic fl, input logic gnt, input logic rv,
        input logic [63:0] rd, input logic e_req, input logic e_we, input logic [55:0] e_addr,
        input logic e_sgnt, input logic e_stall, input logic e_ack, input logic e_busy);
        vec_t v;
        v.sbr = sbr; v.sba = sba; v.emp = emp; v.amor = amor; v.amoa = amoa;
        v.fl = fl; v.gnt = gnt; v.rv = rv; v.rd = rd;
        v.e_req = e_req; v.e_we = e_we; v.e_addr = e_addr; v.e_sgnt = e_sgnt;
        v.e_stall = e_stall; v.e_ack = e_ack; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic drive_defaults();
        bus.flush_i      = 1'b0;
        bus.sb_req_i     = 1'b0;
        bus.sb_addr_i    = A_SB;
        bus.sb_wdata_i   = 64'h5555_AAAA_5555_AAAA;
        bus.sb_be_i      = 8'hFF;
        bus.sb_size_i    = 2'd3;
        bus.sb_empty_i   = 1'b1;
        bus.amo_req_i    = 1'b0;
        bus.amo_addr_i   = A_AMO;
        bus.amo_wdata_i  = 64'h0123_4567_89AB_CDEF;
        bus.amo_be_i     = 8'hF0;
        bus.amo_size_i   = 2'd3;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        // Cycle-by-cycle script: IDLE store, AMO behind three stores, flush in DRAIN, flush in WAIT_RSP
        //           sbr  sba    emp  amor amoa    fl   gnt  rv   rd                   req  we   addr    sgnt stall ack busy
        vecs[0]  = mk(1, A_SB,  0,   0,  A_AMO,  0,   1,   0,   64'h0,                1,   1,   A_SB,   1,   0,    0,  0);
        vecs[1]  = mk(1, A_SB,  0,   0,  A_AMO,  0,   0,   0,   64'h0,                1,   1,   A_SB,   0,   0,    0,  0);
        vecs[2]  = mk(0, A_SB,  1,   0,  A_AMO,  0,   0,   1,   64'h0,                0,   1,   A_SB,   0,   0,    0,  0);
        vecs[3]  = mk(1, A1,    0,   1,  A_AMO,  0,   0,   0,   64'h0,                1,   1,   A1,     0,   0,    0,  0);
        vecs[4]  = mk(1, A1,    0,   0,  A_BAD,  0,   1,   0,   64'h0,                1,   1,   A1,     1,   0,    0,  1);
        vecs[5]  = mk(1, A2,    0,   0,  A_BAD,  0,   0,   0,   64'h0,                1,   1,   A2,     0,   0,    0,  1);
        vecs[6]  = mk(1, A2,    0,   0,  A_BAD,  0,   1,   0,   64'h0,                1,   1,   A2,     1,   0,    0,  1);
        vecs[7]  = mk(1, A3,    0,   0,  A_BAD,  0,   0,   0,   64'h0,                1,   1,   A3,     0,   0,    0,  1);
        vecs[8]  = mk(1, A3,    0,   0,  A_BAD,  0,   1,   0,   64'h0,                1,   1,   A3,     1,   0,    0,  1);
        vecs[9]  = mk(0, A3,    1,   0,  A_BAD,  0,   0,   0,   64'h0,                0,   1,   A3,     0,   0,    0,  1);
        vecs[10] = mk(1, A4,    0,   0,  A_BAD,  0,   0,   0,   64'h0,                1,   0,   A_AMO,  0,   1,    0,  1);
        vecs[11] = mk(1, A4,    0,   0,  A_BAD,  0,   1,   0,   64'h0,                1,   0,   A_AMO,  0,   1,    0,  1);
        vecs[12] = mk(0, A4,    0,   0,  A_BAD,  0,   0,   0,   64'h0,                0,   0,   A_AMO,  0,   1,    0,  1);
        vecs[13] = mk(0, A4,    0,   0,  A_BAD,  0,   0,   1,   64'hDEAD_BEEF,        0,   0,   A_AMO,  0,   1,    1,  1);
        vecs[14] = mk(0, A4,    1,   1,  A_AMO,  0,   0,   0,   64'h0,                0,   1,   A4,     0,   0,    0,  0);
        vecs[15] = mk(0, A4,    0,   0,  A_AMO,  1,   0,   0,   64'h0,                0,   1,   A4,     0,   0,    0,  1);
        vecs[16] = mk(0, A4,    1,   0,  A_AMO,  0,   0,   0,   64'h0,                0,   1,   A4,     0,   0,    0,  0);
        vecs[17] = mk(0, A4,    1,   1,  A_AMO2, 0,   0,   0,   64'h0,                0,   1,   A4,     0,   0,    0,  0);
        vecs[18] = mk(0, A4,    1,   0,  A_BAD,  0,   0,   0,   64'h0,                0,   1,   A4,     0,   0,    0,  1);
        vecs[19] = mk(0, A4,    1,   0,  A_BAD,  1,   1,   0,   64'h0,                1,   0,   A_AMO2, 0,   1,    0,  1);
        vecs[20] = mk(0, A4,    1,   0,  A_BAD,  1,   0,   0,   64'h0,                0,   0,   A_AMO2, 0,   1,    0,  1);
        vecs[21] = mk(0, A4,    1,   0,  A_BAD,  1,   0,   1,   64'h1234_5678,        0,   0,   A_AMO2, 0,   1,    1,  1);
        vecs[22] = mk(0, A4,    1,   0,  A_BAD,  0,   0,   0,   64'h0,                0,   1,   A4,     0,   0,    0,  0);

        // Reset: requests driven high must not leak through
        drive_defaults();
        bus.sb_req_i     = 1'b1;
        bus.mem_gnt_i    = 1'b1;
        bus.mem_rvalid_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", 64'(bus.mem_req_o), 64'd0);
        check("rst_sb_gnt", 64'(bus.sb_gnt_o), 64'd0);
        check("rst_sb_stall", 64'(bus.sb_stall_o), 64'd0);
        check("rst_amo_ack", 64'(bus.amo_ack_o), 64'd0);
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        drive_defaults();
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            bus.sb_req_i     = vecs[i].sbr;
            bus.sb_addr_i    = vecs[i].sba;
            bus.sb_empty_i   = vecs[i].emp;
            bus.amo_req_i    = vecs[i].amor;
            bus.amo_addr_i   = vecs[i].amoa;
            bus.flush_i      = vecs[i].fl;
            bus.mem_gnt_i    = vecs[i].gnt;
            bus.mem_rvalid_i = vecs[i].rv;
            bus.mem_rdata_i  = vecs[i].rd;
            @(negedge clk);
            check($sformatf("v%0d_mem_req", i), 64'(bus.mem_req_o), 64'(vecs[i].e_req));
            if (vecs[i].e_req) begin
                check($sformatf("v%0d_mem_we", i), 64'(bus.mem_we_o), 64'(vecs[i].e_we));
                check($sformatf("v%0d_mem_addr", i), 64'(bus.mem_addr_o), 64'(vecs[i].e_addr));
            end
            check($sformatf("v%0d_sb_gnt", i), 64'(bus.sb_gnt_o), 64'(vecs[i].e_sgnt));
            check($sformatf("v%0d_sb_stall", i), 64'(bus.sb_stall_o), 64'(vecs[i].e_stall));
            check($sformatf("v%0d_amo_ack", i), 64'(bus.amo_ack_o), 64'(vecs[i].e_ack));
            if (vecs[i].e_ack) begin
                check($sformatf("v%0d_amo_rdata", i), 64'(bus.amo_rdata_o), vecs[i].rd);
            end
            check($sformatf("v%0d_busy", i), 64'(bus.busy_o), 64'(vecs[i].e_busy));
            @(posedge clk);
            #1;
        end

        // ISSUE held without grant for 5 cycles: AMO fields stable, store buffer locked out
        drive_defaults();
        bus.amo_req_i   = 1'b1;
        bus.amo_addr_i  = A5;
        bus.amo_wdata_i = W5;
        bus.amo_be_i    = 8'h0F;
        @(posedge clk); #1;
        bus.amo_req_i   = 1'b0;
        @(posedge clk); #1;
        bus.amo_addr_i  = A_BAD;
        bus.amo_wdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.amo_be_i    = 8'hAA;
        bus.sb_req_i    = 1'b1;
        bus.sb_empty_i  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("hold%0d_mem_req", c), 64'(bus.mem_req_o), 64'd1);
            check($sformatf("hold%0d_mem_addr", c), 64'(bus.mem_addr_o), 64'(A5));
            check($sformatf("hold%0d_mem_wdata", c), 64'(bus.mem_wdata_o), W5);
            check($sformatf("hold%0d_mem_be", c), 64'(bus.mem_be_o), 64'h0F);
            check($sformatf("hold%0d_sb_gnt", c), 64'(bus.sb_gnt_o), 64'd0);
            @(posedge clk); #1;
        end
        bus.sb_req_i  = 1'b0;
        bus.mem_gnt_i = 1'b1;
        @(posedge clk); #1;
        bus.mem_gnt_i = 1'b0;

        // Reset in WAIT_RSP: outputs drop at once and the AMO is never acknowledged
        @(negedge clk);
        check("wait_busy", 64'(bus.busy_o), 64'd1);
        check("wait_mem_req", 64'(bus.mem_req_o), 64'd0);
        @(posedge clk); #2;
        bus.sb_req_i     = 1'b1;
        bus.mem_gnt_i    = 1'b1;
        bus.mem_rvalid_i = 1'b1;
        rst_ni = 1'b0;
        #1;
        check("arst_mem_req", 64'(bus.mem_req_o), 64'd0);
        check("arst_sb_gnt", 64'(bus.sb_gnt_o), 64'd0);
        check("arst_sb_stall", 64'(bus.sb_stall_o), 64'd0);
        check("arst_amo_ack", 64'(bus.amo_ack_o), 64'd0);
        check("arst_busy", 64'(bus.busy_o), 64'd0);
        @(negedge clk);
        bus.sb_req_i  = 1'b0;
        bus.mem_gnt_i = 1'b0;
        rst_ni = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("post_rst%0d_ack", c), 64'(bus.amo_ack_o), 64'd0);
            check($sformatf("post_rst%0d_busy", c), 64'(bus.busy_o), 64'd0);
        end
        drive_defaults();

`ifdef STORE_PORT_SEQ_DRAIN_WDOG_EN
        // Drain watchdog: buffer never empties, stall at DRAIN cycle DLIM, then ISSUE
        @(posedge clk); #1;
        bus.amo_req_i  = 1'b1;
        bus.sb_empty_i = 1'b0;
        @(posedge clk); #1;
        bus.amo_req_i  = 1'b0;
        for (int c = 1; c <= int'(DLIM); c++) begin
            bus.mem_gnt_i = (c == int'(DLIM));
            @(negedge clk);
            check($sformatf("wd%0d_stall", c), 64'(bus.sb_stall_o), 64'(c == int'(DLIM)));
            check($sformatf("wd%0d_pulse", c), 64'(bus.drain_wdog_o), 64'(c == int'(DLIM)));
            if (c == int'(DLIM)) begin
                check("wd_sb_gnt_blocked", 64'(bus.sb_gnt_o), 64'd0);
            end
            @(posedge clk); #1;
        end
        bus.mem_gnt_i = 1'b0;
        @(negedge clk);
        check("wd_issue_stall", 64'(bus.sb_stall_o), 64'd1);
        check("wd_issue_req", 64'(bus.mem_req_o), 64'd1);
        check("wd_issue_we", 64'(bus.mem_we_o), 64'd0);
        check("wd_issue_pulse", 64'(bus.drain_wdog_o), 64'd0);
        @(posedge clk); #1;
        bus.mem_gnt_i = 1'b1;
        @(posedge clk); #1;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        @(negedge clk);
        check("wd_ack", 64'(bus.amo_ack_o), 64'd1);
        @(posedge clk); #1;
        drive_defaults();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
